clap_pattern_decoder: RTL and testbench
=======================================

Name: clap_pattern_decoder

Overview:
- Sits directly downstream of the clap detector and consumes its clap_detected output.
- Groups claps that arrive within a timing window into a single command: 1, 2 or up to MAX_CLAPS claps.
- Suppresses re-triggering from one clap's ringing with a lockout period.
- Presents the clap count to the home-appliance control logic over a valid/ready handshake.

Parameters:
- LOCKOUT_CYCLES, 2_500_000: cycles after an accepted clap during which further clap edges are ignored (50 ms at 50 MHz).
- WINDOW_CYCLES, 25_000_000: cycles after lockout ends in which a further clap extends the sequence (0.5 s at 50 MHz).
- MAX_CLAPS, 3: clap count at which the sequence closes immediately; range 2..3.
- TMR_W, 25: timer width; must hold max(LOCKOUT_CYCLES, WINDOW_CYCLES)-1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- clap_in  in  1  clap_detected from the detector; a level, and only its rising edge counts.
- enable  in  1  decoder enable; low aborts any in-progress sequence.
- cmd_ready  in  1  consumer accepts the command.
- cmd_valid  out  1  command available.
- cmd_count  out  2  number of claps in the sequence (1..MAX_CLAPS); meaningful only while cmd_valid=1.
- busy  out  1  high in any state other than IDLE.
- dropped  out  1  one-cycle pulse when a clap edge is discarded in REPORT.

Behaviour:
- One clock domain; one always block is asynchronous-reset on negedge resetn.
- Reset values:
  - state=IDLE, timer=0, count=0, clap_q=0.
  - cmd_valid=0, cmd_count=0, busy=0, dropped=0.
- Edge detect: clap_q is a register of clap_in; clap_edge = clap_in & ~clap_q. The edge is visible in the same cycle clap_in rises.
- IDLE:
  - clap_edge & enable -> count=1, timer=0, next state LOCKOUT.
  - clap_edge with enable=0 is ignored.
- LOCKOUT:
  - timer increments each cycle, and clap edges are ignored.
  - When timer==LOCKOUT_CYCLES-1: timer=0 and go to WAIT_NEXT.
  - Total dwell is exactly LOCKOUT_CYCLES cycles.
- WAIT_NEXT: timer increments each cycle.
  - clap_edge -> count+1. If the new count==MAX_CLAPS go to REPORT; else timer=0 and go to LOCKOUT.
  - Timeout when timer==WINDOW_CYCLES-1 with no edge -> REPORT.
  - Clap edge in the same cycle as timeout: the clap wins, counted as above.
- REPORT:
  - cmd_valid=1 and cmd_count=count, both registered and stable until acceptance.
  - Transfer happens on cmd_valid & cmd_ready at a clock edge. Next cycle: cmd_valid=0, count=0, state IDLE.
  - A clap edge in REPORT is discarded and pulses dropped for one cycle.
- enable=0 in LOCKOUT or WAIT_NEXT: next cycle state=IDLE, count=0, timer=0. No command is issued.
- enable=0 in REPORT has no effect: once raised, valid is never withdrawn until accepted.
- Latency: a single clap whose edge arrives at cycle t gives cmd_valid=1 at t+1+LOCKOUT_CYCLES+WINDOW_CYCLES.
- cmd_ready high while in IDLE has no effect.
- busy = (state != IDLE).
- count never exceeds MAX_CLAPS. The timer never wraps, because it is cleared on every state change.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). A pending command is lost.

Decomposition:
- Shared package clap_pkg:
  - state encoding IDLE=2'd0, LOCKOUT=2'd1, WAIT_NEXT=2'd2, REPORT=2'd3.
  - command meanings CMD_SINGLE=2'd1 (toggle lights), CMD_DOUBLE=2'd2 (toggle fan), CMD_TRIPLE=2'd3 (all off), used by consumers.
- One natural sub-module: cycle_timer, a clearable up-counter with a terminal-compare output; it is instantiated once and its compare value is muxed by state.

Test Plan:
- Use LOCKOUT_CYCLES=4, WINDOW_CYCLES=10, MAX_CLAPS=3 and cmd_ready held at 1 unless stated.
- Single clap, edge at t0 -> busy=1 from t0+1; cmd_valid=1, cmd_count=1 at t0+15; valid for one cycle; IDLE at t0+16.
- Double clap, edges at t0 and t0+8 -> the second edge is counted; cmd_count=2 with cmd_valid at t0+23.
- Triple clap, edges at t0, t0+6, t0+12 -> cmd_valid=1 and cmd_count=3 at t0+13, with no window wait.
- Lockout bounce: edges at t0, t0+2, t0+4 (the last at the final lockout cycle) -> only the first counts; cmd_count=1 at t0+15.
- Backpressure: cmd_ready=0 when cmd_valid rises.
  - cmd_valid and cmd_count stay stable for 20 cycles.
  - A clap edge during the wait pulses dropped once.
  - Raising cmd_ready -> transfer, then IDLE next cycle.
- Abort and reset:
  - enable=0 at t0+7 after an edge at t0 -> IDLE at t0+8, and cmd_valid never rises.
  - resetn=0 during REPORT -> cmd_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/clap_pattern_decoder_pkg.sv
// ---------------------------------------------------------------------------
// clap_pkg
//   Shared definitions for the clap pattern decoder and its consumers.
//   - state_t     : decoder FSM encoding
//   - cmd_count_t : width of the clap count handed to the control logic
//   - CMD_*       : meaning of each clap count for the appliance controller
// ---------------------------------------------------------------------------
package clap_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCKOUT   = 2'd1,
        WAIT_NEXT = 2'd2,
        REPORT    = 2'd3
    } state_t;

    typedef logic [1:0] cmd_count_t;

    // Command meanings, interpreted by the downstream control logic.
    localparam cmd_count_t CMD_SINGLE = 2'd1;  // toggle lights
    localparam cmd_count_t CMD_DOUBLE = 2'd2;  // toggle fan
    localparam cmd_count_t CMD_TRIPLE = 2'd3;  // all off

endpackage

// File: rtl/clap_pattern_decoder_if.sv
// ---------------------------------------------------------------------------
// clap_pattern_decoder_if
//   Valid/ready command channel from the clap decoder to the control logic.
//   Ports / signals:
//     cmd_valid  master -> slave  command available
//     cmd_count  master -> slave  clap count, meaningful while cmd_valid=1
//     cmd_ready  slave  -> master consumer accepts the command
//   Modports: master (decoder side), slave (consumer side).
// ---------------------------------------------------------------------------
interface clap_pattern_decoder_if;
    import clap_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    cmd_count_t cmd_count;

    modport master (
        output cmd_valid,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/clap_pattern_decoder_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
//   Clearable up-counter with a terminal-compare output.
//   Ports:
//     clk            in   system clock
//     resetn         in   asynchronous active-low reset
//     clear          in   synchronous clear to zero (has priority over run)
//     run            in   count up by one this cycle
//     terminal_value in   value compared against the current count
//     at_terminal    out  current count equals terminal_value
// ---------------------------------------------------------------------------
module cycle_timer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] terminal_value,
    output logic         at_terminal
);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (run) begin
            value <= value + W'(1);
        end
    end

    assign at_terminal = (value == terminal_value);

endmodule

// File: rtl/clap_pattern_decoder.sv
// ---------------------------------------------------------------------------
// clap_pattern_decoder
//   Groups rising edges of the clap detector output into a single command
//   of 1..MAX_CLAPS claps. Each accepted clap is followed by a lockout
//   period (ringing suppression) and then a window in which another clap
//   extends the sequence. The final count is offered over valid/ready.
//   Ports:
//     clk        in   system clock
//     resetn     in   asynchronous active-low reset
//     clap_in    in   clap_detected level; only its rising edge counts
//     enable     in   decoder enable; low aborts a sequence in progress
//     cmd        if   master modport: cmd_valid/cmd_count out, cmd_ready in
//     busy       out  FSM is not in IDLE
//     dropped    out  one-cycle pulse when a clap edge arrives in REPORT
// ---------------------------------------------------------------------------
module clap_pattern_decoder
    import clap_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 2_500_000,
    parameter int WINDOW_CYCLES  = 25_000_000,
    parameter int MAX_CLAPS      = 3,
    parameter int TMR_W          = 25
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clap_in,
    input  logic                  enable,
    clap_pattern_decoder_if.master cmd,
    output logic                  busy,
    output logic                  dropped
);

    state_t     state;
    state_t     state_next;
    cmd_count_t count;
    cmd_count_t count_next;
    cmd_count_t clap_total;
    logic       clap_q;
    logic       clap_edge;

    logic       cmd_valid_q;
    logic       cmd_valid_next;
    cmd_count_t cmd_count_q;
    cmd_count_t cmd_count_next;
    logic       dropped_next;

    logic             timer_clear;
    logic             timer_run;
    logic [TMR_W-1:0] timer_limit;
    logic             timer_done;

    // The edge is combinational so it is seen in the same cycle clap_in rises.
    assign clap_edge = clap_in & ~clap_q;

    // One shared timer; its terminal value depends on which phase we are in.
    assign timer_limit = (state == LOCKOUT) ? TMR_W'(LOCKOUT_CYCLES - 1)
                                            : TMR_W'(WINDOW_CYCLES - 1);
    assign timer_run   = (state == LOCKOUT) || (state == WAIT_NEXT);

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk            (clk),
        .resetn         (resetn),
        .clear          (timer_clear),
        .run            (timer_run),
        .terminal_value (timer_limit),
        .at_terminal    (timer_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            count       <= '0;
            clap_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_count_q <= '0;
            dropped     <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            clap_q      <= clap_in;
            cmd_valid_q <= cmd_valid_next;
            cmd_count_q <= cmd_count_next;
            dropped     <= dropped_next;
        end
    end

    // Next-state logic. The timer is cleared on every state change, so it
    // never needs to wrap. cmd_valid/cmd_count are loaded on the transition
    // into REPORT so they are registered and stable until acceptance.
    always_comb begin
        state_next     = state;
        count_next     = count;
        clap_total     = count + 2'd1;
        timer_clear    = 1'b0;
        cmd_valid_next = cmd_valid_q;
        cmd_count_next = cmd_count_q;
        dropped_next   = 1'b0;

        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (clap_edge && enable) begin
                    count_next = 2'd1;
                    state_next = LOCKOUT;
                end
            end

            LOCKOUT: begin
                if (!enable) begin
                    state_next  = IDLE;
                    count_next  = '0;
                    timer_clear = 1'b1;
                end else if (timer_done) begin
                    state_next  = WAIT_NEXT;
                    timer_clear = 1'b1;
                end
            end

            WAIT_NEXT: begin
                if (!enable) begin
                    state_next  = IDLE;
                    count_next  = '0;
                    timer_clear = 1'b1;
                end else if (clap_edge) begin
                    // A clap coinciding with the window timeout still counts.
                    count_next  = clap_total;
                    timer_clear = 1'b1;
                    if (clap_total == 2'(MAX_CLAPS)) begin
                        state_next     = REPORT;
                        cmd_valid_next = 1'b1;
                        cmd_count_next = clap_total;
                    end else begin
                        state_next = LOCKOUT;
                    end
                end else if (timer_done) begin
                    state_next     = REPORT;
                    timer_clear    = 1'b1;
                    cmd_valid_next = 1'b1;
                    cmd_count_next = count;
                end
            end

            REPORT: begin
                // enable is ignored here: a raised command is never withdrawn.
                timer_clear = 1'b1;
                if (clap_edge) begin
                    dropped_next = 1'b1;
                end
                if (cmd_valid_q && cmd.cmd_ready) begin
                    state_next     = IDLE;
                    count_next     = '0;
                    cmd_valid_next = 1'b0;
                    cmd_count_next = '0;
                end
            end

            default: begin
                state_next     = IDLE;
                count_next     = '0;
                timer_clear    = 1'b1;
                cmd_valid_next = 1'b0;
                cmd_count_next = '0;
            end
        endcase
    end

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_count = cmd_count_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_clap_pattern_decoder.sv
// ---------------------------------------------------------------------------
// tb_clap_pattern_decoder
//   Directed bench for clap_pattern_decoder with LOCKOUT_CYCLES=4,
//   WINDOW_CYCLES=10, MAX_CLAPS=3. Inputs change 1 time unit after the
//   rising clock edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_clap_pattern_decoder;
    import clap_pkg::*;

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic clap_in = 1'b0;
    logic enable  = 1'b0;
    logic busy;
    logic dropped;

    int errors = 0;
    int checks = 0;
    int seen   = 0;

    clap_pattern_decoder_if cmd_bus ();

    clap_pattern_decoder #(
        .LOCKOUT_CYCLES (4),
        .WINDOW_CYCLES  (10),
        .MAX_CLAPS      (3),
        .TMR_W          (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .clap_in (clap_in),
        .enable  (enable),
        .cmd     (cmd_bus.master),
        .busy    (busy),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive clap_in high for exactly one cycle, ending one cycle later.
    task automatic apply_stimulus();
        clap_in = 1'b1;
        step();
        clap_in = 1'b0;
    endtask

    initial begin
        cmd_bus.cmd_ready = 1'b1;

        // Reset state
        step(2);
        check_output("rst_valid",   cmd_bus.cmd_valid, 0);
        check_output("rst_count",   cmd_bus.cmd_count, 0);
        check_output("rst_busy",    busy, 0);
        check_output("rst_dropped", dropped, 0);
        resetn = 1'b1;
        enable = 1'b1;
        step(2);

        // Single clap: valid at t0+15, idle at t0+16
        $display("[TB] single clap");
        apply_stimulus();                               // t0+1
        check_output("single_busy", busy, 1);
        step(13);                                       // t0+14
        check_output("single_valid_early", cmd_bus.cmd_valid, 0);
        step();                                         // t0+15
        check_output("single_valid", cmd_bus.cmd_valid, 1);
        check_output("single_count", cmd_bus.cmd_count, CMD_SINGLE);
        step();                                         // t0+16
        check_output("single_valid_drop", cmd_bus.cmd_valid, 0);
        check_output("single_idle", busy, 0);
        step(2);

        // Double clap: edges at t0 and t0+8, valid at t0+23
        $display("[TB] double clap");
        apply_stimulus();                               // t0+1
        step(7);                                        // t0+8
        apply_stimulus();                               // t0+9
        step(13);                                       // t0+22
        check_output("double_valid_early", cmd_bus.cmd_valid, 0);
        step();                                         // t0+23
        check_output("double_valid", cmd_bus.cmd_valid, 1);
        check_output("double_count", cmd_bus.cmd_count, CMD_DOUBLE);
        step();
        check_output("double_idle", busy, 0);
        step(2);

        // Triple clap: edges at t0, t0+6, t0+12, valid at t0+13
        $display("[TB] triple clap");
        apply_stimulus();                               // t0+1
        step(5);                                        // t0+6
        apply_stimulus();                               // t0+7
        step(5);                                        // t0+12
        check_output("triple_valid_early", cmd_bus.cmd_valid, 0);
        apply_stimulus();                               // t0+13
        check_output("triple_valid", cmd_bus.cmd_valid, 1);
        check_output("triple_count", cmd_bus.cmd_count, CMD_TRIPLE);
        step();
        check_output("triple_idle", busy, 0);
        step(2);

        // Abort: edge at t0, enable low at t0+7 -> idle at t0+8, no command
        $display("[TB] abort");
        apply_stimulus();                               // t0+1
        step(6);                                        // t0+7
        enable = 1'b0;
        step();                                         // t0+8
        check_output("abort_idle", busy, 0);
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_bus.cmd_valid) seen++;
            step();
        end
        check_output("abort_no_valid", seen, 0);

        // Lockout bounce: edges at t0, t0+2, t0+4; only the first counts
        $display("[TB] lockout bounce");
        apply_stimulus();                               // t0+1
        step();                                         // t0+2
        apply_stimulus();                               // t0+3
        step();                                         // t0+4
        apply_stimulus();                               // t0+5
        step(9);                                        // t0+14
        check_output("bounce_valid_early", cmd_bus.cmd_valid, 0);
        step();                                         // t0+15
        check_output("bounce_valid", cmd_bus.cmd_valid, 1);
        check_output("bounce_count", cmd_bus.cmd_count, 1);
        step(3);

        // Enable low in IDLE: clap ignored
        enable = 1'b0;
        apply_stimulus();
        check_output("disabled_idle", busy, 0);
        enable = 1'b1;
        step(2);

        // Backpressure: hold 20 cycles, one dropped clap, then accept
        $display("[TB] backpressure");
        cmd_bus.cmd_ready = 1'b0;
        apply_stimulus();                               // t0+1
        step(14);                                       // t0+15
        check_output("bp_valid_rise", cmd_bus.cmd_valid, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            check_output("bp_valid_hold", cmd_bus.cmd_valid, 1);
            check_output("bp_count_hold", cmd_bus.cmd_count, 1);
            if (dropped) seen++;
            clap_in = (i == 5);
            step();
        end
        check_output("bp_dropped_pulses", seen, 1);
        check_output("bp_still_busy", busy, 1);
        cmd_bus.cmd_ready = 1'b1;
        step();
        check_output("bp_valid_after", cmd_bus.cmd_valid, 0);
        check_output("bp_idle_after", busy, 0);
        step(2);

        // Reset during REPORT clears valid before the next clock edge
        $display("[TB] reset in report");
        cmd_bus.cmd_ready = 1'b0;
        apply_stimulus();                               // t0+1
        step(5);                                        // t0+6
        apply_stimulus();                               // t0+7
        step(5);                                        // t0+12
        apply_stimulus();                               // t0+13
        check_output("rr_valid", cmd_bus.cmd_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_output("rr_valid_cleared", cmd_bus.cmd_valid, 0);
        check_output("rr_count_cleared", cmd_bus.cmd_count, 0);
        check_output("rr_busy_cleared", busy, 0);
        step(2);
        resetn = 1'b1;
        cmd_bus.cmd_ready = 1'b1;
        step();
        apply_stimulus();
        check_output("rr_recover_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
